// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: shared FSM state type and vector entry layout helpers
package vector_checker_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // entry layout, msb to lsb: {valid, in[nin], exp[nout], mask[nout]}
  function automatic int entry_width(int nin, int nout);
    return 1 + nin + 2 * nout;
  endfunction
  function automatic int exp_lsb(int nout);
    return nout;
  endfunction
  function automatic int in_lsb(int nout);
    return 2 * nout;
  endfunction
  function automatic int valid_bit(int nin, int nout);
    return nin + 2 * nout;
  endfunction
endpackage

// File: rtl/vector_checker_if.sv
// vector_checker_if: vector load, run control, DUT stimulus/response and result bus
// slave = checker side, master = host/bench side
interface vector_checker_if #(
  parameter int NIN = 3,
  parameter int NOUT = 1,
  parameter int DEPTH = 16,
  parameter int CNTW = 32
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic vec_we;
  logic [AW-1:0] vec_waddr;
  logic [NIN+2*NOUT:0] vec_wdata;
  logic start;
  logic [NIN-1:0] dut_in;
  logic [NOUT-1:0] dut_out;
  logic busy;
  logic done;
  logic pass;
  logic [CNTW-1:0] vectornum;
  logic [CNTW-1:0] errors;
  logic first_err_valid;
  logic [AW-1:0] first_err_idx;
  modport slave (
    input vec_we, vec_waddr, vec_wdata, start, dut_out,
    output dut_in, busy, done, pass, vectornum, errors, first_err_valid, first_err_idx
  );
  modport master (
    output vec_we, vec_waddr, vec_wdata, start, dut_out,
    input dut_in, busy, done, pass, vectornum, errors, first_err_valid, first_err_idx
  );
endinterface

// File: rtl/vector_checker_delay_line.sv
// delay_line: DEPTH-stage register pipe, DEPTH=0 is a plain wire
// ports: clk, reset (async, active-high, clears stages), din, dout
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ reset;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];
    always_comb begin
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk or posedge reset)
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= reset ? '0 : sr_d[i];
    assign dout = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/vector_checker.sv
// vector_checker: replays stored vectors into a DUT and checks masked responses after LAT clocks
// ports: clk, reset (async, active-high), bus (vector load, start, dut_in/dut_out, status and counters)
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int NIN = 3,
  parameter int NOUT = 1,
  parameter int DEPTH = 16,
  parameter int LAT = 0,
  parameter int CNTW = 32
) (
  input logic clk,
  input logic reset,
  vector_checker_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int VB = valid_bit(NIN, NOUT);
  localparam int IL = in_lsb(NOUT);
  localparam int XL = exp_lsb(NOUT);
  localparam int SW = 1 + AW + 2 * NOUT;
  localparam int LW = LAT > 1 ? $clog2(LAT) : 1;
  state_t state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic [LW-1:0] drn_q, drn_d;
  logic [NIN-1:0] din_q, din_d;
  logic [SW-1:0] a_q, a_d, c_w;
  logic [CNTW-1:0] vnum_q, vnum_d, err_q, err_d;
  logic fev_q, fev_d;
  logic [AW-1:0] fidx_q, fidx_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [VB-1:0] mem_q [DEPTH];
  logic [VB-1:0] ent;
  logic busy, wr, rd_ok, mism;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign wr = bus.vec_we && !busy && 32'(bus.vec_waddr) < DEPTH;
  // idx reaches DEPTH on a full memory; the range test keeps that from reading an entry
  assign rd_ok = idx_q < (AW+1)'(DEPTH) && vld_q[idx_q[AW-1:0]];
  assign ent = mem_q[idx_q[AW-1:0]];
  assign mism = c_w[SW-1] && |((bus.dut_out ^ c_w[XL+:NOUT]) & c_w[NOUT-1:0]);
  always_comb begin
    vld_d = vld_q;
    if (wr) vld_d[bus.vec_waddr] = bus.vec_wdata[VB];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    drn_d = drn_q;
    din_d = din_q;
    a_d = '0;
    vnum_d = vnum_q + CNTW'(c_w[SW-1]);
    err_d = err_q + CNTW'(mism && !(&err_q));
    fev_d = fev_q | mism;
    fidx_d = mism && !fev_q ? c_w[SW-2-:AW] : fidx_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = RUN;
        idx_d = '0;
        vnum_d = '0;
        err_d = '0;
        fev_d = 1'b0;
        fidx_d = '0;
      end
      RUN: begin
        a_d = rd_ok ? {1'b1, idx_q[AW-1:0], ent[IL-1:0]} : '0;
        din_d = rd_ok ? ent[IL+:NIN] : din_q;
        idx_d = rd_ok ? idx_q + 1'b1 : idx_q;
        drn_d = '0;
        state_d = rd_ok ? RUN : (LAT == 0 ? DONE : DRAIN);
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        state_d = int'(drn_q) == LAT - 1 ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      drn_q <= '0;
      din_q <= '0;
      a_q <= '0;
      vnum_q <= '0;
      err_q <= '0;
      fev_q <= 1'b0;
      fidx_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      drn_q <= drn_d;
      din_q <= din_d;
      a_q <= a_d;
      vnum_q <= vnum_d;
      err_q <= err_d;
      fev_q <= fev_d;
      fidx_q <= fidx_d;
      vld_q <= vld_d;
    end
  // payload bits carry no reset; only the valid bits decide what a run sees
  always_ff @(posedge clk)
    if (wr) mem_q[bus.vec_waddr] <= bus.vec_wdata[VB-1:0];
  delay_line #(.WIDTH(SW), .DEPTH(LAT)) u_dl (.clk(clk), .reset(reset), .din(a_q), .dout(c_w));
  assign bus.dut_in = din_q;
  assign bus.busy = busy;
  assign bus.done = state_q == DONE;
  assign bus.pass = state_q == DONE && err_q == '0;
  assign bus.vectornum = vnum_q;
  assign bus.errors = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx = fidx_q;
endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: random and directed vector runs on two checker configurations against a run-level model
module tb_vector_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vector_checker_if #(.NIN(3), .NOUT(1), .DEPTH(16), .CNTW(32)) b0 ();
  vector_checker_if #(.NIN(4), .NOUT(4), .DEPTH(16), .CNTW(32)) b1 ();
  vector_checker #(.NIN(3), .NOUT(1), .DEPTH(16), .LAT(0), .CNTW(32)) u0 (.clk(clk), .reset(reset), .bus(b0));
  vector_checker #(.NIN(4), .NOUT(4), .DEPTH(16), .LAT(2), .CNTW(32)) u1 (.clk(clk), .reset(reset), .bus(b1));
  logic [1:0] we, st;
  logic [3:0] wa [2];
  logic [12:0] wd [2];
  assign b0.vec_we = we[0];
  assign b0.vec_waddr = wa[0];
  assign b0.vec_wdata = wd[0][5:0];
  assign b0.start = st[0];
  assign b1.vec_we = we[1];
  assign b1.vec_waddr = wa[1];
  assign b1.vec_wdata = wd[1];
  assign b1.start = st[1];
  assign b0.dut_out = (~b0.dut_in[1] & ~b0.dut_in[0]) | (b0.dut_in[2] & ~b0.dut_in[1]);
  logic [3:0] r1, r2;
  always @(posedge clk) begin
    r1 <= b1.dut_in + 4'd3;
    r2 <= r1;
  end
  assign b1.dut_out = r2;
  int din_o [2], busy_o [2], done_o [2], pass_o [2], vn_o [2], er_o [2], fv_o [2], fi_o [2];
  assign din_o[0] = int'(b0.dut_in);
  assign din_o[1] = int'(b1.dut_in);
  assign busy_o[0] = int'(b0.busy);
  assign busy_o[1] = int'(b1.busy);
  assign done_o[0] = int'(b0.done);
  assign done_o[1] = int'(b1.done);
  assign pass_o[0] = int'(b0.pass);
  assign pass_o[1] = int'(b1.pass);
  assign vn_o[0] = int'(b0.vectornum);
  assign vn_o[1] = int'(b1.vectornum);
  assign er_o[0] = int'(b0.errors);
  assign er_o[1] = int'(b1.errors);
  assign fv_o[0] = int'(b0.first_err_valid);
  assign fv_o[1] = int'(b1.first_err_valid);
  assign fi_o[0] = int'(b0.first_err_idx);
  assign fi_o[1] = int'(b1.first_err_idx);
  int checks = 0;
  int failures = 0;
  bit tv [2][16];
  logic [3:0] ti [2][16], te [2][16], tm [2][16];
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] f(int s, logic [3:0] x);
    return s != 0 ? x + 4'd3 : {3'b0, (~x[1] & ~x[0]) | (x[2] & ~x[1])};
  endfunction
  function automatic logic [3:0] om(int s);
    return s != 0 ? 4'hF : 4'h1;
  endfunction
  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) tv[s][a] = 1'b0;
  endtask
  task automatic wr(int s, int a, bit v, logic [3:0] i, logic [3:0] e, logic [3:0] m);
    @(negedge clk);
    we[s] = 1'b1;
    wa[s] = a[3:0];
    wd[s] = s != 0 ? {v, i, e, m} : {7'b0, v, i[2:0], e[0], m[0]};
    @(negedge clk);
    we[s] = 1'b0;
    tv[s][a] = v;
    ti[s][a] = i & (s != 0 ? 4'hF : 4'h7);
    te[s][a] = e & om(s);
    tm[s][a] = m & om(s);
  endtask
  task automatic load(int s, int n, int perr);
    for (int a = 0; a < 16; a++) begin
      bit v;
      logic [3:0] i, e, m;
      v = a < n ? 1'b1 : (a == n ? 1'b0 : 1'($urandom_range(0, 1)));
      i = 4'($urandom) & (s != 0 ? 4'hF : 4'h7);
      e = f(s, i);
      if ($urandom_range(0, 99) < perr) e = e ^ 4'(1 << $urandom_range(0, s != 0 ? 3 : 0));
      m = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF;
      wr(s, a, v, i, e, m);
    end
  endtask
  task automatic model(int s, output int n, output int e, output int fi, output int fv);
    n = 0;
    while (n < 16 && tv[s][n]) n++;
    e = 0;
    fi = 0;
    fv = 0;
    for (int k = 0; k < n; k++)
      if (((f(s, ti[s][k]) ^ te[s][k]) & tm[s][k]) != 4'h0) begin
        if (fv == 0) fi = k;
        fv = 1;
        e++;
      end
  endtask
  task automatic run(int s, bit poke);
    int n, e, fi, fv, cyc, dbad, bbad, lat;
    model(s, n, e, fi, fv);
    lat = n + 1 + (s != 0 ? 2 : 0);
    @(negedge clk);
    st[s] = 1'b1;
    @(posedge clk);
    #1;
    st[s] = 1'b0;
    cyc = 0;
    dbad = 0;
    bbad = 0;
    while (done_o[s] == 0 && cyc < 100) begin
      if (busy_o[s] != 1) bbad++;
      if (cyc >= 1 && cyc <= n && din_o[s] != int'(ti[s][cyc-1])) dbad++;
      if (poke && cyc == 2) begin
        we[s] = 1'b1;
        wa[s] = 4'd0;
        wd[s] = '0;
      end
      if (cyc == 3) we[s] = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    we[s] = 1'b0;
    chk($sformatf("s%0d.done_latency", s), cyc, lat);
    chk($sformatf("s%0d.busy_gaps", s), bbad, 0);
    chk($sformatf("s%0d.dut_in_seq", s), dbad, 0);
    chk($sformatf("s%0d.busy_at_done", s), busy_o[s], 0);
    chk($sformatf("s%0d.vectornum", s), vn_o[s], n);
    chk($sformatf("s%0d.errors", s), er_o[s], e);
    chk($sformatf("s%0d.pass", s), pass_o[s], e == 0 ? 1 : 0);
    chk($sformatf("s%0d.first_err_valid", s), fv_o[s], fv);
    chk($sformatf("s%0d.first_err_idx", s), fi_o[s], fi);
    if (n > 0) chk($sformatf("s%0d.dut_in_hold", s), din_o[s], int'(ti[s][n-1]));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    we = '0;
    st = '0;
    wa[0] = '0;
    wa[1] = '0;
    wd[0] = '0;
    wd[1] = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("s%0d.rst_dut_in", s), din_o[s], 0);
      chk($sformatf("s%0d.rst_busy", s), busy_o[s], 0);
      chk($sformatf("s%0d.rst_done", s), done_o[s], 0);
      chk($sformatf("s%0d.rst_pass", s), pass_o[s], 0);
      chk($sformatf("s%0d.rst_counts", s), vn_o[s] + er_o[s] + fv_o[s] + fi_o[s], 0);
    end
    run(0, 1'b0);
    run(1, 1'b0);
    for (int a = 0; a < 8; a++) wr(0, a, 1'b1, 4'(a), f(0, 4'(a)), 4'h1);
    run(0, 1'b0);
    wr(0, 5, 1'b1, 4'd5, 4'd0, 4'h1);
    run(0, 1'b0);
    wr(0, 5, 1'b1, 4'd5, 4'd0, 4'h0);
    run(0, 1'b1);
    run(0, 1'b0);
    for (int a = 0; a < 16; a++) begin
      logic [3:0] i;
      i = 4'($urandom);
      wr(1, a, 1'b1, i, f(1, i), 4'hF);
    end
    run(1, 1'b0);
    repeat (8)
      for (int s = 0; s < 2; s++) begin
        load(s, $urandom_range(0, 16), 25);
        run(s, 1'b0);
      end
    for (int a = 0; a < 9; a++) wr(0, a, a < 8, 4'(a), f(0, 4'(a)), 4'h1);
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid.busy_before_reset", busy_o[0], 1);
    reset = 1'b1;
    #1;
    chk("mid.busy", busy_o[0], 0);
    chk("mid.done", done_o[0], 0);
    chk("mid.dut_in", din_o[0], 0);
    chk("mid.vectornum", vn_o[0], 0);
    chk("mid.errors", er_o[0], 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run(0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
